// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter (fetch, operand read, result write) for one single-port memory.
// Define MEM_PORT_ARBITER_RR_EN for round-robin arbitration; the default is fixed priority wr > rd > fetch.
module mem_port_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_rvalid,
  input  logic         rd_req,
  input  logic [N-1:0] rd_addr,
  output logic         rd_gnt,
  output logic         rd_rvalid,
  input  logic         wr_req,
  input  logic [N-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  output logic         wr_gnt,
  output logic [N-1:0] rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_rd_en,
  output logic         mem_wr_en,
  input  logic [N-1:0] mem_rd_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] ID_IF = 2'd0;
  localparam logic [1:0] ID_RD = 2'd1;
  localparam logic [1:0] ID_WR = 2'd2;

  state_t       state_q, state_d;
  logic [1:0]   win_q, win_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] data_q, data_d;
  logic [1:0]   sel;
  logic         any_req;

  assign any_req = if_req | rd_req | wr_req;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic [1:0] last_q, last_d;

  // The requester after the last winner gets first look.
  always_comb begin
    sel = ID_IF;
    case (last_q)
      ID_IF: begin
        if (rd_req)      sel = ID_RD;
        else if (wr_req) sel = ID_WR;
        else             sel = ID_IF;
      end
      ID_RD: begin
        if (wr_req)      sel = ID_WR;
        else if (if_req) sel = ID_IF;
        else             sel = ID_RD;
      end
      default: begin
        if (if_req)      sel = ID_IF;
        else if (rd_req) sel = ID_RD;
        else             sel = ID_WR;
      end
    endcase
  end

  assign last_d = (state_q == IDLE && any_req) ? sel : last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= ID_WR;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    sel = ID_IF;
    if (wr_req)      sel = ID_WR;
    else if (rd_req) sel = ID_RD;
    else             sel = ID_IF;
  end
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    if_rvalid = 1'b0;
    rd_rvalid = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    rdata     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d   = sel;
          state_d = GRANT;
          case (sel)
            ID_IF:   addr_d = if_addr;
            ID_RD:   addr_d = rd_addr;
            default: begin
              addr_d = wr_addr;
              data_d = wr_data;
            end
          endcase
        end
      end
      GRANT: begin
        if_gnt = (win_q == ID_IF);
        rd_gnt = (win_q == ID_RD);
        wr_gnt = (win_q == ID_WR);
        if (win_q == ID_WR) begin
          mem_wr_en = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_rd_en = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if_rvalid = (win_q == ID_IF);
        rd_rvalid = (win_q == ID_RD);
        rdata     = mem_rd_data;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and write data stay on the memory port between accesses.
  assign mem_addr    = addr_q;
  assign mem_wr_data = data_q;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      win_q   <= ID_IF;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model (schedule of grants and a shadow memory).
module tb_mem_port_arbiter;

  localparam int N     = 8;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         if_req = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic [N-1:0] if_addr = '0, rd_addr = '0, wr_addr = '0, wr_data = '0;
  logic         if_gnt, if_rvalid, rd_gnt, rd_rvalid, wr_gnt;
  logic [N-1:0] rdata, mem_addr, mem_wr_data, mem_rd_data;
  logic         mem_rd_en, mem_wr_en, busy;

  mem_port_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] initVal(input int a);
    if (a == 16) return 8'hA5;
    return N'(a * 7 + 3);
  endfunction

  // Bench-side single-port memory with one cycle read latency
  logic         init_mem = 1'b1;
  logic [N-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= initVal(i);
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end
  end

  // Reference model: one transaction at a time, described by its grant cycle
  logic [N-1:0] m_mem [DEPTH];
  int           cyc, m_next_free, m_start, m_id, m_last;
  bit           m_wr;
  logic [N-1:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;
  int gnt_log[$];
  bit if_hold = 1'b0;
  bit [2:0] just_granted;
  int exp_order[3];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelMemInit();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = initVal(i);
  endtask

  task automatic modelReset();
    m_next_free = 0;
    m_start     = -100;
    m_id        = 0;
    m_wr        = 1'b0;
    m_last      = 2;
    m_addr      = '0;
    m_wdata     = '0;
    m_rdata     = '0;
  endtask

  // Requester ids: 0 fetch, 1 operand read, 2 write
  function automatic int pick(input bit [2:0] r);
`ifdef MEM_PORT_ARBITER_RR_EN
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = (m_last + i) % 3;
      if (r[c]) return c;
    end
`else
    for (int c = 2; c >= 0; c--) if (r[c]) return c;
`endif
    return -1;
  endfunction

  // Called once the inputs for the current cycle are final
  task automatic modelDecide();
    int w;
    w = pick({wr_req, rd_req, if_req});
    if (cyc >= m_next_free && w >= 0) begin
      m_start = cyc + 1;
      m_id    = w;
      m_wr    = (w == 2);
      m_last  = w;
      case (w)
        0:       m_addr = if_addr;
        1:       m_addr = rd_addr;
        default: m_addr = wr_addr;
      endcase
      if (m_wr) begin
        m_wdata        = wr_data;
        m_mem[m_addr]  = wr_data;
        m_next_free    = m_start + 1;
      end else begin
        m_rdata     = m_mem[m_addr];
        m_next_free = m_start + 2;
      end
    end
  endtask

  // One cycle: compare at the falling edge, then apply the requester handshake
  task automatic tick();
    bit         g, v;
    logic [2:0] eg, ev;
    @(negedge clk);
    cyc++;
    g  = (cyc == m_start);
    v  = !m_wr && (cyc == m_start + 1);
    eg = g ? (3'b001 << m_id) : 3'b000;
    ev = v ? (3'b001 << m_id) : 3'b000;
    checkOutput("gnt", 32'({wr_gnt, rd_gnt, if_gnt}), 32'(eg));
    checkOutput("rvalid", 32'({1'b0, rd_rvalid, if_rvalid}), 32'(ev));
    checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(g && !m_wr));
    checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(g && m_wr));
    checkOutput("busy", 32'(busy), 32'(g || v));
    checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
    checkOutput("mem_wr_data", 32'(mem_wr_data), 32'(m_wdata));
    checkOutput("rdata", 32'(rdata), v ? 32'(m_rdata) : 32'd0);
    checkOutput("one_gnt", 32'($countones({if_gnt, rd_gnt, wr_gnt}) <= 1), 32'd1);
    checkOutput("one_rvalid", 32'($countones({if_rvalid, rd_rvalid}) <= 1), 32'd1);
    checkOutput("strobe_excl", 32'(!(mem_rd_en && mem_wr_en)), 32'd1);
    just_granted = {wr_gnt, rd_gnt, if_gnt};
    if (if_gnt) gnt_log.push_back(0);
    if (rd_gnt) gnt_log.push_back(1);
    if (wr_gnt) gnt_log.push_back(2);
    if (if_gnt && !if_hold) if_req = 1'b0;
    if (rd_gnt) rd_req = 1'b0;
    if (wr_gnt) wr_req = 1'b0;
  endtask

  task automatic doReset();
    reset   = 1'b0;
    if_req  = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    if_hold = 1'b0;
    init_mem = 1'b1;
    modelReset();
    modelMemInit();
    tick();
    tick();
    reset    = 1'b1;
    init_mem = 1'b0;
    cyc      = 0;
  endtask

  // Random requester behaviour: idle requesters occasionally raise a new request
  task automatic applyStimulus();
    if (!if_req && !just_granted[0] && $urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = N'($urandom_range(0, 15));
    end
    if (!rd_req && !just_granted[1] && $urandom_range(0, 2) == 0) begin
      rd_req  = 1'b1;
      rd_addr = N'($urandom_range(0, 15));
    end
    if (!wr_req && !just_granted[2] && $urandom_range(0, 2) == 0) begin
      wr_req  = 1'b1;
      wr_addr = N'($urandom_range(0, 15));
      wr_data = N'($urandom);
    end
  endtask

  initial begin
    int p, rd_pos, nfetch;
`ifdef MEM_PORT_ARBITER_RR_EN
    exp_order = '{0, 1, 2};
`else
    exp_order = '{2, 1, 0};
`endif
    cyc = 0;
    just_granted = 3'b000;
    doReset();

    // Single fetch from a preloaded location
    if_req = 1'b1; if_addr = 8'h10;
    modelDecide();
    tick();
    checkOutput("fetch_gnt", 32'(if_gnt), 32'd1);
    checkOutput("fetch_rd_en", 32'(mem_rd_en), 32'd1);
    checkOutput("fetch_addr", 32'(mem_addr), 32'h10);
    modelDecide();
    tick();
    checkOutput("fetch_rvalid", 32'(if_rvalid), 32'd1);
    checkOutput("fetch_rdata", 32'(rdata), 32'hA5);
    modelDecide();
    tick();
    checkOutput("fetch_busy_done", 32'(busy), 32'd0);

    // Write followed by a read-back of the same address
    doReset();
    wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'h3C;
    modelDecide();
    tick();
    checkOutput("wr_gnt", 32'(wr_gnt), 32'd1);
    checkOutput("wr_strobe", 32'(mem_wr_en), 32'd1);
    checkOutput("wr_addr", 32'(mem_addr), 32'h20);
    checkOutput("wr_data", 32'(mem_wr_data), 32'h3C);
    modelDecide();
    tick();
    checkOutput("wr_idle", 32'(busy), 32'd0);
    rd_req = 1'b1; rd_addr = 8'h20;
    modelDecide();
    tick();
    modelDecide();
    tick();
    checkOutput("readback_rvalid", 32'(rd_rvalid), 32'd1);
    checkOutput("readback_rdata", 32'(rdata), 32'h3C);
    modelDecide();
    tick();

    // All three requesters at once out of reset
    doReset();
    gnt_log.delete();
    if_req = 1'b1; if_addr = 8'h01;
    rd_req = 1'b1; rd_addr = 8'h02;
    wr_req = 1'b1; wr_addr = 8'h03; wr_data = 8'h77;
    modelDecide();
    for (int i = 0; i < 20 && gnt_log.size() < 3; i++) begin
      tick();
      modelDecide();
    end
    checkOutput("order_count", 32'(gnt_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < gnt_log.size(); i++)
      checkOutput($sformatf("order_%0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));
    repeat (4) begin tick(); modelDecide(); end

    // Fetch held high must not starve a single operand read
    doReset();
    if_hold = 1'b1; if_req = 1'b1; if_addr = 8'h05;
    modelDecide();
    repeat (4) begin tick(); modelDecide(); end
    rd_req = 1'b1; rd_addr = 8'h06;
    p = gnt_log.size();
    rd_pos = -1;
    modelDecide();
    for (int i = 0; i < 20 && rd_pos < 0; i++) begin
      tick();
      modelDecide();
      for (int j = p; j < gnt_log.size(); j++)
        if (gnt_log[j] == 1 && rd_pos < 0) rd_pos = j - p + 1;
    end
    nfetch = 0;
    for (int j = p; j < p + rd_pos - 1 && j < gnt_log.size(); j++)
      if (gnt_log[j] == 0) nfetch++;
    checkOutput("rd_within_two", 32'(rd_pos >= 1 && rd_pos <= 2), 32'd1);
    checkOutput("no_double_fetch", 32'(nfetch <= 1), 32'd1);
    if_hold = 1'b0; if_req = 1'b0;
    repeat (4) begin tick(); modelDecide(); end

    // Reset pulled during the read-wait cycle of an operand read
    doReset();
    rd_req = 1'b1; rd_addr = 8'h33;
    modelDecide();
    tick();
    checkOutput("abort_rd_gnt", 32'(rd_gnt), 32'd1);
    if_hold = 1'b1; if_req = 1'b1; if_addr = 8'h44;
    modelDecide();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_outputs_zero",
      32'({if_gnt, rd_gnt, wr_gnt, if_rvalid, rd_rvalid, mem_rd_en, mem_wr_en, busy}), 32'd0);
    checkOutput("abort_addr_data_zero", 32'({rdata, mem_addr, mem_wr_data}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    cyc = 0;
    modelDecide();
    tick();
    checkOutput("abort_fetch_at_1", 32'(if_gnt), 32'd1);
    if_hold = 1'b0; if_req = 1'b0;
    repeat (4) begin tick(); modelDecide(); end

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      modelDecide();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
